// File: rtl/fma_seq.sv
// Sequencer for fmadd/fmsub/fnmsub/fnmadd: latches sign-adjusted operands, then
// steps them through one combinational fmul and one fsub with a register per stage.
module fmul (
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic [31:0] out_mul
);
  logic        s, nan1, nan2, inf1, inf2, zero1, zero2, guard, sticky;
  logic [7:0]  e1, e2;
  logic [47:0] prod;
  logic [22:0] mant;
  logic [24:0] rnd;
  logic [9:0]  e_n;

  always_comb begin
    s      = num1[31] ^ num2[31];
    e1     = num1[30:23];
    e2     = num2[30:23];
    nan1   = (e1 == 8'hFF) && (num1[22:0] != 23'd0);
    nan2   = (e2 == 8'hFF) && (num2[22:0] != 23'd0);
    inf1   = (e1 == 8'hFF) && (num1[22:0] == 23'd0);
    inf2   = (e2 == 8'hFF) && (num2[22:0] == 23'd0);
    zero1  = (e1 == 8'd0);
    zero2  = (e2 == 8'd0);
    prod   = {24'd0, 1'b1, num1[22:0]} * {24'd0, 1'b1, num2[22:0]};
    e_n    = {2'b00, e1} + {2'b00, e2} - 10'd127 + {9'd0, prod[47]};
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    // round to nearest, ties to even; a carry out bumps the exponent
    rnd = {2'b01, mant} + {24'd0, guard & (sticky | mant[0])};
    if (rnd[24]) e_n = e_n + 10'd1;

    if (nan1 || nan2)
      out_mul = 32'h7FC0_0000;
    else if (inf1 || inf2)
      out_mul = (zero1 || zero2) ? 32'h7FC0_0000 : {s, 8'hFF, 23'd0};
    else if (zero1 || zero2)
      out_mul = {s, 31'd0};
    else if (!e_n[9] && (e_n >= 10'd255))
      out_mul = {s, 8'hFF, 23'd0};
    else if (e_n[9] || (e_n == 10'd0))
      out_mul = {s, 31'd0};
    else
      out_mul = {s, e_n[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
  end
endmodule

// res = var1 - var2, round to nearest even; subnormal inputs/outputs flush to zero.
module fsub (
  input  logic [31:0] var1,
  input  logic [31:0] var2,
  output logic [31:0] res
);
  logic [31:0] nb, x, y;
  logic        eff_sub, lost, guard, sticky;
  logic [7:0]  ex, ey, d;
  logic [4:0]  sh;
  logic [50:0] mx, my, my_sh, sum;
  logic [49:0] nrm;
  logic [5:0]  p;
  logic [9:0]  e_n;
  logic [24:0] rnd;

  always_comb begin
    nb = {~var2[31], var2[30:0]};
    if (var1[30:0] >= nb[30:0]) begin
      x = var1;
      y = nb;
    end else begin
      x = nb;
      y = var1;
    end
    ex      = x[30:23];
    ey      = y[30:23];
    eff_sub = x[31] ^ y[31];
    d       = ex - ey;
    // beyond 31 places the smaller operand only matters as a sticky bit
    sh      = (d > 8'd31) ? 5'd31 : d[4:0];
    mx      = {2'b01, x[22:0], 26'd0};
    my      = {2'b01, y[22:0], 26'd0};
    my_sh   = my >> sh;
    lost    = |(my & ~({51{1'b1}} << sh));
    my_sh[0] = my_sh[0] | lost;
    sum     = eff_sub ? (mx - my_sh) : (mx + my_sh);
    p = 6'd0;
    for (int i = 0; i < 51; i++)
      if (sum[i]) p = 6'(i);
    nrm    = 50'(sum << (6'd50 - p));
    e_n    = {2'b00, ex} + {4'd0, p} - 10'd49;
    guard  = nrm[26];
    sticky = |nrm[25:0];
    rnd    = {2'b01, nrm[49:27]} + {24'd0, guard & (sticky | nrm[27])};
    if (rnd[24]) e_n = e_n + 10'd1;

    if (ex == 8'hFF) begin
      if ((x[22:0] != 23'd0) || ((ey == 8'hFF) && ((y[22:0] != 23'd0) || eff_sub)))
        res = 32'h7FC0_0000;
      else
        res = {x[31], 8'hFF, 23'd0};
    end else if (ex == 8'd0)
      res = {var1[31] & nb[31], 31'd0};
    else if (ey == 8'd0)
      res = x;
    else if (sum == 51'd0)
      res = 32'd0;
    else if (!e_n[9] && (e_n >= 10'd255))
      res = {x[31], 8'hFF, 23'd0};
    else if (e_n[9] || (e_n == 10'd0))
      res = {x[31], 31'd0};
    else
      res = {x[31], e_n[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
  end
endmodule

module fma_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  input  logic [3:0]  in_tag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [3:0]  out_tag,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SUB, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        accept, ld_prod, ld_res;
  logic [31:0] a_q, b_q, c_q, prod_q, res_q, mul_out, sub_out;
  logic [3:0]  tag_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_MUL;
      S_MUL:                  state_d = S_SUB;
      S_SUB:                  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    accept    = in_valid && in_ready;
    ld_prod   = (state_q == S_MUL);
    ld_res    = (state_q == S_SUB);
  end

  // product sign flips for ops 1x; addend flips for ops x0 so the subtract adds c
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      tag_q  <= '0;
      prod_q <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        a_q   <= {in_a[31] ^ in_op[1], in_a[30:0]};
        b_q   <= in_b;
        c_q   <= {in_c[31] ^ ~in_op[0], in_c[30:0]};
        tag_q <= in_tag;
      end
      if (ld_prod) prod_q <= mul_out;
      if (ld_res)  res_q  <= sub_out;
    end
  end

  fmul u_fmul (.num1(a_q),    .num2(b_q), .out_mul(mul_out));
  fsub u_fsub (.var1(prod_q), .var2(c_q), .res(sub_out));

  assign out_res = res_q;
  assign out_tag = tag_q;
endmodule

// File: tb/tb_fma_seq.sv
// Directed checks of fma_seq: op variants, latency, throughput, stall, reset abort.
module tb_fma_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b, in_c, out_res;
  logic [3:0]  in_tag, out_tag;
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [31:0] F2 = 32'h4000_0000, F3 = 32'h4040_0000, F1 = 32'h3F80_0000;

  fma_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [3:0] tag);
    in_op = op; in_a = a; in_b = b; in_c = c; in_tag = tag; in_valid = 1'b1;
  endtask

  task automatic wait_out(input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk({nm, "_seen"}, 32'(out_valid), 32'd1);
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [3:0] tag,
                        input logic [31:0] exp);
    int n;
    issue(op, a, b, c, tag);
    chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
    n = 0;
    do begin
      step();
      n++;
      in_valid = 1'b0;
      if (n == 1) chk({nm, "_busy"}, {31'd0, busy, out_valid}, 32'd2);
    end while (!out_valid && n < 10);
    chk({nm, "_lat"}, 32'(n), 32'd3);
    chk({nm, "_res"}, out_res, exp);
    chk({nm, "_tag"}, 32'(out_tag), 32'(tag));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int acc_cyc[3];
    int nacc, nout;
    logic acc, hs;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; in_a = '0; in_b = '0; in_c = '0; in_tag = '0;
    step(); step();
    chk("rst_rdy",  32'(in_ready), 32'd0);
    chk("rst_ctl",  {30'd0, busy, out_valid}, 32'd0);
    chk("rst_res",  out_res, 32'd0);
    chk("rst_tag",  32'(out_tag), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 32'(in_ready), 32'd1);

    run_op("fmadd",  2'b00, F2, F3, F1, 4'd5,  32'h40E0_0000);
    run_op("fmsub",  2'b01, F2, F3, F1, 4'd10, 32'h40A0_0000);
    run_op("fnmsub", 2'b10, F2, F3, F1, 4'd11, 32'hC0A0_0000);
    run_op("fnmadd", 2'b11, F2, F3, F1, 4'd12, 32'hC0E0_0000);
    run_op("frac",   2'b00, 32'h3FC0_0000, 32'h3FC0_0000, 32'h3E80_0000, 4'd13, 32'h4020_0000);
    run_op("cancel", 2'b01, F2, F3, 32'h40C0_0000, 4'd14, 32'h0000_0000);
    run_op("tie",    2'b00, F1, F1, 32'h3380_0000, 4'd15, 32'h3F80_0000);

    // back-to-back offers with the consumer always ready
    issue(2'b00, F2, F3, F1, 4'd1);
    out_ready = 1'b1;
    nacc = 0; nout = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (acc && nacc < 3) begin acc_cyc[nacc] = cyc; nacc++; end
      if (hs) begin
        chk("b2b_tag", 32'(out_tag), 32'(nout + 1));
        chk("b2b_res", out_res, 32'h40E0_0000);
        nout++;
      end
      step();
      if (acc) begin
        if (in_tag == 4'd3) in_valid = 1'b0;
        else                in_tag = in_tag + 4'd1;
      end
    end
    out_ready = 1'b0;
    chk("b2b_nacc", 32'(nacc), 32'd3);
    chk("b2b_nout", 32'(nout), 32'd3);
    chk("b2b_acc0", 32'(acc_cyc[0]), 32'd0);
    chk("b2b_acc1", 32'(acc_cyc[1]), 32'd4);
    chk("b2b_acc2", 32'(acc_cyc[2]), 32'd8);

    // consumer stalls for 5 cycles
    issue(2'b00, F2, F3, F1, 4'd9);
    step();
    in_valid = 1'b0;
    wait_out("stall");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_res", out_res, 32'h40E0_0000);
      chk("stall_tag", 32'(out_tag), 32'd9);
      chk("stall_ctl", {29'd0, in_ready, busy, out_valid}, 32'd3);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("stall_rel", {30'd0, in_ready, busy}, 32'd2);

    // operands change right after the accept edge
    issue(2'b00, F2, F3, F1, 4'd6);
    step();
    in_valid = 1'b0; in_a = '0; in_c = '0;
    wait_out("late_chg");
    chk("late_chg_res", out_res, 32'h40E0_0000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // reset pulse while in SUB aborts the transaction
    issue(2'b00, F2, F3, F1, 4'd7);
    step();
    in_valid = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rdy_in_rst", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("abort_rdy", 32'(in_ready), 32'd1);
    chk("abort_res", out_res, 32'd0);
    chk("abort_tag", 32'(out_tag), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_ov", {30'd0, busy, out_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
